// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath: run/IR in,
// strobes, register selects, ALU opcode and status out.
interface control_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             Run;
    logic [31:0]      IR;
    logic             PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin;
    logic             Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
    logic [15:0]      Rin;
    logic [15:0]      Rout;
    logic [4:0]       opcode;
    logic             Done;
    logic             Halted;
    logic [CNT_W-1:0] Instr_count;

    modport master (
        input  Run, IR,
        output PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
               Read, MDRin, MDRout, IRin, Yin, HIin, LOin,
               Rin, Rout, opcode, Done, Halted, Instr_count
    );

    modport slave (
        output Run, IR,
        input  PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
               Read, MDRin, MDRout, IRin, Yin, HIin, LOin,
               Rin, Rout, opcode, Done, Halted, Instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer. Controls are decoded from the
// state register (plus IR fields for register selects), so clear zeroes them at once.
module control_sequencer #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                clear_i,
    control_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_e;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_e           state_q;
    logic [2:0]       wait_q;
    logic [CNT_W-1:0] cnt_q;

    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic       is_alu3, is_muldiv, is_halt, is_nop;
    logic       end_instr;
    logic       unused_ir;

    assign opc       = bus.IR[31:27];
    assign ra        = bus.IR[26:23];
    assign rb        = bus.IR[22:19];
    assign rc        = bus.IR[18:15];
    assign unused_ir = ^bus.IR[14:0];

    assign is_alu3   = (opc >= 5'd3) && (opc <= 5'd10);
    assign is_muldiv = (opc == 5'd15) || (opc == 5'd16);
    assign is_halt   = (opc == 5'd27);
    assign is_nop    = !(is_alu3 || is_muldiv || is_halt);

    // T5 retires anything that is not mul/div, so Done and the next state agree.
    assign end_instr = ((state_q == S_T2) && is_nop)
                    || ((state_q == S_T5) && !is_muldiv)
                    ||  (state_q == S_T6);

    always_ff @(posedge clk_i or posedge clear_i) begin
        if (clear_i) begin
            state_q <= S_IDLE;
            wait_q  <= 3'd0;
            cnt_q   <= '0;
        end else begin
            if (end_instr)
                cnt_q <= cnt_q + 1'b1;
            case (state_q)
                S_IDLE: if (bus.Run) state_q <= S_T0;
                S_T0: begin
                    state_q <= S_T1;
                    wait_q  <= 3'd0;
                end
                S_T1: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q <= S_T2;
                        wait_q  <= 3'd0;
                    end else begin
                        wait_q  <= wait_q + 3'd1;
                    end
                end
                S_T2: begin
                    if (is_nop)       state_q <= bus.Run ? S_T0 : S_IDLE;
                    else if (is_halt) state_q <= S_HALT;
                    else              state_q <= S_T3;
                end
                S_T3: state_q <= S_T4;
                S_T4: state_q <= S_T5;
                S_T5: begin
                    if (is_muldiv) state_q <= S_T6;
                    else           state_q <= bus.Run ? S_T0 : S_IDLE;
                end
                S_T6:   state_q <= bus.Run ? S_T0 : S_IDLE;
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.PCout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Zin      = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.PCin     = 1'b0;
        bus.Read     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.Rin      = 16'h0000;
        bus.Rout     = 16'h0000;
        bus.opcode   = 5'd0;
        bus.Halted   = 1'b0;
        case (state_q)
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            // PC writeback on the first wait cycle, MDR capture on the last.
            S_T1: begin
                bus.Read    = 1'b1;
                bus.Zlowout = (wait_q == 3'd0);
                bus.PCin    = (wait_q == 3'd0);
                bus.MDRin   = (wait_q == WAIT_LAST);
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                bus.Rout[rb] = 1'b1;
                bus.Yin      = 1'b1;
            end
            S_T4: begin
                bus.Rout[rc] = 1'b1;
                bus.opcode   = opc;
                bus.Zin      = 1'b1;
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (is_muldiv) bus.LOin    = 1'b1;
                else           bus.Rin[ra] = 1'b1;
            end
            S_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
            end
            S_HALT: bus.Halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.Done        = end_instr;
    assign bus.Instr_count = cnt_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer: three instances cover
// MEM_WAIT=0, MEM_WAIT=2 and a 4-bit counter for the wrap case.
module tb_control_sequencer;
    localparam logic [31:0] ADD  = 32'h18918000;
    localparam logic [31:0] MUL  = 32'h78228000;
    localparam logic [31:0] NOP  = 32'hD0000000;
    localparam logic [31:0] HALT = 32'hD8000000;

    // control bit order: PCout MARin IncPC Zin Zlowout Zhighout PCin Read MDRin MDRout IRin Yin HIin LOin
    localparam logic [13:0] PCOUT = 14'h2000, MARIN = 14'h1000, INCPC = 14'h0800, ZIN   = 14'h0400;
    localparam logic [13:0] ZLO   = 14'h0200, ZHI   = 14'h0100, PCIN  = 14'h0080, READ  = 14'h0040;
    localparam logic [13:0] MDRIN = 14'h0020, MDROUT= 14'h0010, IRIN  = 14'h0008, YIN   = 14'h0004;
    localparam logic [13:0] HIIN  = 14'h0002, LOIN  = 14'h0001;
    localparam logic [13:0] F_T0 = PCOUT | MARIN | INCPC | ZIN;
    localparam logic [13:0] F_T1 = ZLO | PCIN | READ | MDRIN;
    localparam logic [13:0] F_T2 = MDROUT | IRIN;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr0, clr2, clr4;

    control_sequencer_if #(.CNT_W(16)) if0 ();
    control_sequencer_if #(.CNT_W(16)) if2 ();
    control_sequencer_if #(.CNT_W(4))  if4 ();

    control_sequencer #(.MEM_WAIT(0), .CNT_W(16)) dut0 (.clk_i(clk), .clear_i(clr0), .bus(if0));
    control_sequencer #(.MEM_WAIT(2), .CNT_W(16)) dut2 (.clk_i(clk), .clear_i(clr2), .bus(if2));
    control_sequencer #(.MEM_WAIT(0), .CNT_W(4))  dut4 (.clk_i(clk), .clear_i(clr4), .bus(if4));

    // {ctl[13:0], Rin, Rout, opcode, Done, Halted, Instr_count (16b)} = 69 bits
    logic [68:0] obs0, obs2, obs4;
    assign obs0 = {if0.PCout, if0.MARin, if0.IncPC, if0.Zin, if0.Zlowout, if0.Zhighout, if0.PCin,
                   if0.Read, if0.MDRin, if0.MDRout, if0.IRin, if0.Yin, if0.HIin, if0.LOin,
                   if0.Rin, if0.Rout, if0.opcode, if0.Done, if0.Halted, if0.Instr_count};
    assign obs2 = {if2.PCout, if2.MARin, if2.IncPC, if2.Zin, if2.Zlowout, if2.Zhighout, if2.PCin,
                   if2.Read, if2.MDRin, if2.MDRout, if2.IRin, if2.Yin, if2.HIin, if2.LOin,
                   if2.Rin, if2.Rout, if2.opcode, if2.Done, if2.Halted, if2.Instr_count};
    assign obs4 = {if4.PCout, if4.MARin, if4.IncPC, if4.Zin, if4.Zlowout, if4.Zhighout, if4.PCin,
                   if4.Read, if4.MDRin, if4.MDRout, if4.IRin, if4.Yin, if4.HIin, if4.LOin,
                   if4.Rin, if4.Rout, if4.opcode, if4.Done, if4.Halted, 12'h000, if4.Instr_count};

    typedef struct {
        int          sel;
        logic        run;
        logic [31:0] ir;
        logic [68:0] exp;
    } vec_t;

    vec_t tv[$];
    int   nvec  = 0;
    int   nfail = 0;

    function automatic logic [68:0] E(logic [13:0] c, logic [15:0] rin, logic [15:0] rout,
                                      logic [4:0] op, logic d, logic h, logic [15:0] cnt);
        return {c, rin, rout, op, d, h, cnt};
    endfunction

    function automatic void addv(int sel, logic run, logic [31:0] ir, logic [68:0] exp);
        vec_t v;
        v.sel = sel; v.run = run; v.ir = ir; v.exp = exp;
        tv.push_back(v);
    endfunction

    task automatic check(string name, logic [68:0] act, logic [68:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vecs(string tag, int lo, int hi);
        for (int i = lo; i < hi; i++) begin
            case (tv[i].sel)
                0: begin if0.Run = tv[i].run; if0.IR = tv[i].ir; end
                2: begin if2.Run = tv[i].run; if2.IR = tv[i].ir; end
                default: begin if4.Run = tv[i].run; if4.IR = tv[i].ir; end
            endcase
            @(posedge clk); #1;
            case (tv[i].sel)
                0:       check($sformatf("%s[%0d]", tag, i - lo), obs0, tv[i].exp);
                2:       check($sformatf("%s[%0d]", tag, i - lo), obs2, tv[i].exp);
                default: check($sformatf("%s[%0d]", tag, i - lo), obs4, tv[i].exp);
            endcase
        end
    endtask

    int a_lo, b_lo, c_lo, c_hi;

    initial begin
        // A: add back-to-back, then Run dropped during T3 of the second add
        a_lo = tv.size();
        addv(0, 1, ADD, E(F_T0, 0, 0,        0, 0, 0, 0));
        addv(0, 1, ADD, E(F_T1, 0, 0,        0, 0, 0, 0));
        addv(0, 1, ADD, E(F_T2, 0, 0,        0, 0, 0, 0));
        addv(0, 1, ADD, E(YIN,  0, 16'h0004, 0, 0, 0, 0));
        addv(0, 1, ADD, E(ZIN,  0, 16'h0008, 5'b00011, 0, 0, 0));
        addv(0, 1, ADD, E(ZLO,  16'h0002, 0, 0, 1, 0, 0));
        addv(0, 1, ADD, E(F_T0, 0, 0,        0, 0, 0, 1));
        addv(0, 1, ADD, E(F_T1, 0, 0,        0, 0, 0, 1));
        addv(0, 1, ADD, E(F_T2, 0, 0,        0, 0, 0, 1));
        addv(0, 0, ADD, E(YIN,  0, 16'h0004, 0, 0, 0, 1));
        addv(0, 0, ADD, E(ZIN,  0, 16'h0008, 5'b00011, 0, 0, 1));
        addv(0, 0, ADD, E(ZLO,  16'h0002, 0, 0, 1, 0, 1));
        addv(0, 0, ADD, E(0,    0, 0,        0, 0, 0, 2));
        addv(0, 0, ADD, E(0,    0, 0,        0, 0, 0, 2));
        // B: one NOP then HALT
        b_lo = tv.size();
        addv(0, 1, NOP,  E(F_T0, 0, 0, 0, 0, 0, 0));
        addv(0, 1, NOP,  E(F_T1, 0, 0, 0, 0, 0, 0));
        addv(0, 1, NOP,  E(F_T2, 0, 0, 0, 1, 0, 0));
        addv(0, 1, NOP,  E(F_T0, 0, 0, 0, 0, 0, 1));
        addv(0, 1, HALT, E(F_T1, 0, 0, 0, 0, 0, 1));
        addv(0, 1, HALT, E(F_T2, 0, 0, 0, 0, 0, 1));
        addv(0, 1, HALT, E(0,    0, 0, 0, 0, 1, 1));
        addv(0, 1, HALT, E(0,    0, 0, 0, 0, 1, 1));
        addv(0, 0, NOP,  E(0,    0, 0, 0, 0, 1, 1));
        // C: mul with MEM_WAIT=2
        c_lo = tv.size();
        addv(2, 1, MUL, E(F_T0,              0, 0,        0, 0, 0, 0));
        addv(2, 1, MUL, E(ZLO | PCIN | READ, 0, 0,        0, 0, 0, 0));
        addv(2, 1, MUL, E(READ,              0, 0,        0, 0, 0, 0));
        addv(2, 1, MUL, E(READ | MDRIN,      0, 0,        0, 0, 0, 0));
        addv(2, 1, MUL, E(F_T2,              0, 0,        0, 0, 0, 0));
        addv(2, 1, MUL, E(YIN,               0, 16'h0010, 0, 0, 0, 0));
        addv(2, 1, MUL, E(ZIN,               0, 16'h0020, 5'b01111, 0, 0, 0));
        addv(2, 1, MUL, E(ZLO | LOIN,        0, 0,        0, 0, 0, 0));
        addv(2, 1, MUL, E(ZHI | HIIN,        0, 0,        0, 1, 0, 0));
        addv(2, 0, MUL, E(0,                 0, 0,        0, 0, 0, 1));
        c_hi = tv.size();

        clr0 = 1'b1; clr2 = 1'b1; clr4 = 1'b1;
        if0.Run = 1'b0; if0.IR = 32'h0;
        if2.Run = 1'b0; if2.IR = 32'h0;
        if4.Run = 1'b0; if4.IR = 32'h0;
        #12;
        check("reset_dut0", obs0, '0);
        check("reset_dut2", obs2, '0);
        check("reset_dut4", obs4, '0);
        @(negedge clk);
        clr0 = 1'b0; clr2 = 1'b0; clr4 = 1'b0;
        @(posedge clk); #1;
        check("idle_run0", obs0, '0);

        run_vecs("add", a_lo, b_lo);

        // clear between edges while in T4
        if0.Run = 1'b1; if0.IR = ADD;
        repeat (5) @(posedge clk);
        #1;
        check("pre_clear_T4", obs0, E(ZIN, 0, 16'h0008, 5'b00011, 0, 0, 2));
        #2 clr0 = 1'b1;
        #1;
        check("clear_async", obs0, '0);
        if0.Run = 1'b0;
        @(negedge clk) clr0 = 1'b0;
        @(posedge clk); #1;
        check("idle_after_clear", obs0, '0);

        run_vecs("nophalt", b_lo, c_lo);
        @(negedge clk) clr0 = 1'b1;
        #1;
        check("halt_clear", obs0, '0);
        @(negedge clk) clr0 = 1'b0;
        @(posedge clk); #1;
        check("halt_clear_idle", obs0, '0);

        run_vecs("mul", c_lo, c_hi);

        // counter wrap on the 4-bit instance with back-to-back NOPs
        if4.Run = 1'b1; if4.IR = NOP;
        @(posedge clk); #1;
        check("wrap_T0", obs4, E(F_T0, 0, 0, 0, 0, 0, 0));
        for (int n = 1; n <= 17; n++) begin
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("wrap_done%0d", n), {obs4[17], obs4[15:0]},
                  {1'b1, 16'((n - 1) % 16)});
            @(posedge clk); #1;
            check($sformatf("wrap_cnt%0d", n), obs4[15:0], 16'(n % 16));
        end
        if4.Run = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
